// File: rtl/id_scoreboard.sv
// Decode-stage register dependency scoreboard: per-register in-flight write counters
// plus a "youngest producer not yet forwardable" flag. Optional SB_CHECK_EN adds sticky sb_err.
module id_scoreboard #(
  parameter int NREG  = 32,
  parameter int AW    = 5,
  parameter int NRD   = 2,
  parameter int CNT_W = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NRD-1:0]    rd_en,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    rd_busy,
  output logic [NRD-1:0]    rd_late,
  output logic              stall,
  input  logic              iss_valid,
  input  logic              iss_we,
  input  logic [AW-1:0]     iss_dest,
  input  logic              iss_late,
  output logic              iss_ready,
  input  logic              fwd_valid,
  input  logic [AW-1:0]     fwd_dest,
  input  logic              wb_valid,
  input  logic [AW-1:0]     wb_dest,
  input  logic              flush
`ifdef SB_CHECK_EN
  ,output logic             sb_err
`endif
);

  localparam logic [CNT_W-1:0] MAXC = '1;

  logic [NREG-1:0][CNT_W-1:0] cnt_q;
  logic [NREG-1:0]            late_q;
  logic [NREG-1:0]            iss_hit, wb_hit, fwd_hit;

  // Entry 0 is never written past reset, so reads of r0 see an idle register.
  assign iss_ready = !(iss_we && (cnt_q[iss_dest] == MAXC));

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] a;
    assign a          = rd_addr[i*AW +: AW];
    assign rd_busy[i] = (a != '0) && (cnt_q[a] != '0);
    assign rd_late[i] = (a != '0) && late_q[a];
  end

  assign stall = (|(rd_en & rd_late)) || !iss_ready;

  always_comb begin
    iss_hit = '0;
    wb_hit  = '0;
    fwd_hit = '0;
    iss_hit[iss_dest] = iss_valid && iss_we && iss_ready && (iss_dest != '0);
    wb_hit[wb_dest]   = wb_valid && (wb_dest != '0) && (cnt_q[wb_dest] != '0);
    fwd_hit[fwd_dest] = fwd_valid && (fwd_dest != '0);
  end

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      cnt_q  <= '0;
      late_q <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (iss_hit[r] && !wb_hit[r])
          cnt_q[r] <= cnt_q[r] + 1'b1;
        else if (!iss_hit[r] && wb_hit[r])
          cnt_q[r] <= cnt_q[r] - 1'b1;
        // A new producer always owns the late flag, even over a same-cycle forward.
        if (iss_hit[r])
          late_q[r] <= iss_late;
        else if (fwd_hit[r] || (wb_hit[r] && cnt_q[r] == CNT_W'(1)))
          late_q[r] <= 1'b0;
      end
    end
  end

`ifdef SB_CHECK_EN
  always_ff @(posedge clk) begin
    if (!resetn)
      sb_err <= 1'b0;
    else if ((wb_valid && (wb_dest != '0) && (cnt_q[wb_dest] == '0)) ||
             (fwd_valid && (fwd_dest != '0) && !late_q[fwd_dest]) ||
             (iss_valid && iss_we && !iss_ready))
      sb_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_id_scoreboard.sv
// Bench for id_scoreboard: directed test-plan steps then random traffic, all checked
// against a per-register count/late reference model.
module tb_id_scoreboard;
  localparam int NREG = 32, AW = 5, NRD = 2, CNT_W = 2;
  localparam int MAXC = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              resetn;
  logic [NRD-1:0]    rd_en;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD-1:0]    rd_busy, rd_late;
  logic              stall, iss_ready;
  logic              iss_valid, iss_we, iss_late;
  logic [AW-1:0]     iss_dest, fwd_dest, wb_dest;
  logic              fwd_valid, wb_valid, flush;
`ifdef SB_CHECK_EN
  logic              sb_err;
`endif

  always #5 clk = ~clk;

  id_scoreboard #(.NREG(NREG), .AW(AW), .NRD(NRD), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_busy(rd_busy), .rd_late(rd_late), .stall(stall),
    .iss_valid(iss_valid), .iss_we(iss_we), .iss_dest(iss_dest), .iss_late(iss_late),
    .iss_ready(iss_ready), .fwd_valid(fwd_valid), .fwd_dest(fwd_dest),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .flush(flush)
`ifdef SB_CHECK_EN
    , .sb_err(sb_err)
`endif
  );

  int checks = 0, failures = 0;
  int mcnt[NREG];
  bit mlate[NREG];
  bit merr;
  bit chk_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_ready();
    return !(iss_we && mcnt[int'(iss_dest)] == MAXC);
  endfunction

  task automatic model_update();
    int d, w, f;
    bit rdy, do_iss, do_wb, do_fwd;
    d = int'(iss_dest); w = int'(wb_dest); f = int'(fwd_dest);
    rdy = m_ready();
    if (!resetn) begin
      merr = 1'b0;
    end else if ((wb_valid && w != 0 && mcnt[w] == 0) ||
                 (fwd_valid && f != 0 && !mlate[f]) ||
                 (iss_valid && !rdy)) begin
      merr = 1'b1;
    end
    if (!resetn || flush) begin
      foreach (mcnt[r]) begin mcnt[r] = 0; mlate[r] = 1'b0; end
      return;
    end
    do_iss = iss_valid && iss_we && rdy && d != 0;
    do_wb  = wb_valid && w != 0 && mcnt[w] > 0;
    do_fwd = fwd_valid && f != 0;
    if (do_fwd) mlate[f] = 1'b0;
    if (do_wb) begin
      mcnt[w] = mcnt[w] - 1;
      if (mcnt[w] == 0) mlate[w] = 1'b0;
    end
    if (do_iss) begin
      mcnt[d] = mcnt[d] + 1;
      mlate[d] = iss_late;
    end
  endtask

  // Inputs are set just after a negedge; outputs are checked mid-cycle, state advances at posedge.
  task automatic cycle();
    logic [NRD-1:0] eb, el;
    bit er;
    int a;
    #1;
    if (chk_en) begin
      for (int i = 0; i < NRD; i++) begin
        a = int'(rd_addr[i*AW +: AW]);
        eb[i] = (a != 0) && (mcnt[a] != 0);
        el[i] = (a != 0) && mlate[a];
      end
      er = m_ready();
      check("rd_busy", 32'(rd_busy), 32'(eb));
      check("rd_late", 32'(rd_late), 32'(el));
      check("iss_ready", 32'(iss_ready), 32'(er));
      check("stall", 32'(stall), 32'((|(rd_en & el)) || !er));
`ifdef SB_CHECK_EN
      check("sb_err", 32'(sb_err), 32'(merr));
`endif
    end
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    iss_valid = 0; iss_we = 0; iss_dest = '0; iss_late = 0;
    fwd_valid = 0; fwd_dest = '0; wb_valid = 0; wb_dest = '0; flush = 0;
  endtask

  task automatic rd(input int a1, input int a0);
    rd_addr = {AW'(a1), AW'(a0)};
    rd_en = 2'b11;
  endtask

  task automatic issue(input int d, input bit lt);
    iss_valid = 1; iss_we = 1; iss_dest = AW'(d); iss_late = lt;
  endtask

  initial begin
    foreach (mcnt[r]) begin mcnt[r] = 0; mlate[r] = 1'b0; end
    merr = 1'b0;
    resetn = 0; idle(); rd(3, 4);
    @(negedge clk);
    cycle(); cycle();
    resetn = 1; chk_en = 1;

    // Reset state, idle reads
    cycle();
    check("reset_busy", 32'(rd_busy), 32'd0);
    check("reset_ready", 32'(iss_ready), 32'd1);

    // Late producer, forward, writeback on r5
    issue(5, 1); cycle(); idle(); rd(0, 5); cycle();
    check("r5_late_stall", 32'(stall), 32'd1);
    fwd_valid = 1; fwd_dest = 5; cycle(); idle(); cycle();
    check("r5_fwd_busy", 32'(rd_busy), 32'd1);
    wb_valid = 1; wb_dest = 5; cycle(); idle(); cycle();

    // Saturation on r7
    rd(0, 7);
    repeat (3) begin issue(7, 0); cycle(); end
    iss_valid = 1; iss_we = 1; iss_dest = 7; cycle();
    check("r7_sat_ready", 32'(iss_ready), 32'd0);
    iss_valid = 0; wb_valid = 1; wb_dest = 7; cycle();
    wb_valid = 0; cycle();
    check("r7_after_wb_ready", 32'(iss_ready), 32'd1);
    idle();
    repeat (2) begin wb_valid = 1; wb_dest = 7; cycle(); end
    idle();

    // Same-cycle combinations on r9
    rd(0, 9);
    issue(9, 1); cycle();
    issue(9, 1); wb_valid = 1; wb_dest = 9; cycle(); idle(); cycle();
    issue(9, 0); fwd_valid = 1; fwd_dest = 9; cycle(); idle(); cycle();
    check("r9_late_cleared", 32'(rd_late), 32'd0);
    idle();

    // Flush beats a simultaneous issue
    issue(2, 0); cycle(); issue(3, 0); cycle(); issue(4, 1); cycle();
    issue(6, 1); flush = 1; cycle(); idle();
    rd(2, 3); cycle(); rd(4, 6); cycle();
    check("flush_busy", 32'(rd_busy), 32'd0);

    // Reset mid-sequence
    issue(11, 1); cycle(); issue(12, 0); cycle(); idle();
    resetn = 0; cycle(); resetn = 1;
    rd(11, 12); cycle();

    // Underflow / bad forward / r0 accesses
    rd(10, 0);
    wb_valid = 1; wb_dest = 10; cycle(); idle(); cycle();
    flush = 1; cycle(); idle(); cycle();
    issue(0, 1); wb_valid = 1; wb_dest = 0; fwd_valid = 1; fwd_dest = 0; cycle();
    idle(); rd(0, 0); cycle();
    fwd_valid = 1; fwd_dest = 13; cycle(); idle(); cycle();

    // Random traffic over a small register window to force collisions and saturation
    for (int n = 0; n < 3000; n++) begin
      resetn    = ($urandom_range(199) != 0);
      rd_en     = NRD'($urandom);
      rd_addr   = {AW'($urandom_range(7)), AW'($urandom_range(7))};
      iss_valid = ($urandom_range(9) < 6);
      iss_we    = ($urandom_range(9) < 8);
      iss_dest  = AW'($urandom_range(7));
      iss_late  = NRD'($urandom) != 0;
      fwd_valid = ($urandom_range(9) < 3);
      fwd_dest  = AW'($urandom_range(7));
      wb_valid  = ($urandom_range(9) < 5);
      wb_dest   = AW'($urandom_range(7));
      flush     = ($urandom_range(39) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/id_scoreboard.md
Name: id_scoreboard

Overview:
- Parametrised register-dependency scoreboard for the decode stage; replaces per-stage destination compares with a tracked pending-write table.
- Counts in-flight writes per architectural register. Separately flags registers whose youngest producer cannot yet be forwarded (load, mul/div).
- Per read port, reports whether decode must stall, plus whether a forwarding path covers the dependency.
- Sits beside the regfile in ID. Fed by the ID issue handshake, result-ready pulses from EXE/MEM, and writeback from WB.

Parameters:
- NREG, 32, number of architectural registers; register 0 never tracked.
- AW, 5, register address width, equal to $clog2(NREG).
- NRD, 2, number of source read ports checked per cycle.
- CNT_W, 2, width of the per-register in-flight counter; maximum count is 2^CNT_W-1.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous reset, active-low.
- rd_en  in  NRD  per port: source operand is used (port i at bit i).
- rd_addr  in  NRD*AW  packed source register numbers; port i at [i*AW +: AW].
- rd_busy  out  NRD  port has a pending write to its register.
- rd_late  out  NRD  youngest pending producer is not yet forwardable.
- stall  out  1  OR over ports of (rd_en & rd_late), OR issue blocked by a full counter.
- iss_valid  in  1  ID instruction handshakes into EXE this cycle (ID_to_EXE_valid & EXE_allowin).
- iss_we  in  1  issuing instruction writes a GPR.
- iss_dest  in  AW  destination register.
- iss_late  in  1  result is produced late (load, mul/div).
- iss_ready  out  1  low when count[iss_dest] == max and iss_we is high.
- fwd_valid  in  1  late result now available on a bypass (MEM load data, mul/div done).
- fwd_dest  in  AW  register of that result.
- wb_valid  in  1  WB commits a GPR write.
- wb_dest  in  AW  register committed.
- flush  in  1  pipeline cancel; clears the whole table.

Behaviour:
- State:
  - cnt[r], CNT_W bits, for r = 1..NREG-1.
  - late[r], 1 bit.
  - Entry 0 is hard-wired to 0.
- Reset (resetn low at posedge clk): all cnt = 0 and late = 0. After reset rd_busy = 0, rd_late = 0, stall = 0, iss_ready = 1.
- Read ports are combinational from registered state, zero latency:
  - rd_busy[i] = cnt[addr_i] != 0.
  - rd_late[i] = late[addr_i].
  - Both outputs are forced to 0 when addr_i == 0.
  - rd_busy is informational; the forward mux uses it.
- Issue event: iss_valid & iss_we & iss_ready & iss_dest != 0.
  - Effect: cnt += 1 and late <= iss_late.
  - late tracks the youngest producer.
- Writeback event: wb_valid & wb_dest != 0 & cnt[wb_dest] != 0.
  - Effect: cnt -= 1.
  - If the new cnt is 0, late <= 0.
- Forward event: fwd_valid & fwd_dest != 0.
  - Effect: late <= 0.
  - Exception: ignored if an issue to the same register occurs in the same cycle; the new producer wins.
- All three events update at the same posedge. Combinations on the same register:
  - issue + writeback: cnt unchanged; late <= iss_late.
  - issue + forward: late <= iss_late.
  - writeback + forward: cnt -= 1; late <= 0.
  - Events on different registers are independent.
- Saturation:
  - iss_ready is computed from the current cnt. A simultaneous writeback does not raise it; the decision is conservative.
  - While iss_ready = 0, stall = 1.
  - An issue with iss_ready = 0 has no effect.
- Underflow: a writeback to a register whose cnt == 0 is ignored and the counter stays 0.
- Flush: all cnt and late are cleared at the next posedge.
  - Flush has priority over every event in the same cycle.
  - The upstream pipeline must discard all in-flight writers together with the flush.
- Register 0: issue, forward and writeback to address 0 are no-ops.

Optional Feature:
- Macro: SB_CHECK_EN.
- Defined:
  - Adds output sb_err (1 bit, reset 0), a sticky flag. It is set on any of:
    - a writeback to a register with cnt == 0;
    - a forward to a register with late == 0;
    - an issue attempted with iss_ready == 0.
  - sb_err is cleared only by reset; flush does not clear it.
- Undefined: the port and checking logic are absent. Behaviour is otherwise identical.

Test Plan:
- Reset then idle: rd_addr = {5'd3, 5'd4}, rd_en = 2'b11 -> rd_busy = 0, rd_late = 0, stall = 0, iss_ready = 1.
- Issue r5 with iss_late = 1, then next cycle read r5 on port 0 -> rd_busy[0] = 1, stall = 1. fwd_valid r5 -> next cycle stall = 0, rd_busy[0] = 1. wb r5 -> rd_busy[0] = 0.
- Issue r7 three times with CNT_W = 2 -> iss_ready = 0 for dest r7 and stall = 1. A fourth issue leaves cnt = 3. One wb r7 -> iss_ready = 1 the next cycle.
- Same cycle issue r9 (late = 1) + wb r9 with cnt = 1 -> cnt stays 1, rd_late = 1. Same cycle fwd r9 + issue r9 (late = 0) -> rd_late = 0.
- Issue r2, r3, r4 (late), then flush together with issue r6 -> all rd_busy = 0 for r2/r3/r4/r6. Asserting resetn low mid-sequence gives the same cleared state.
- With SB_CHECK_EN: wb r10 with cnt = 0 -> cnt stays 0, sb_err = 1 next cycle and it persists through a flush. Accesses to r0 never set busy or sb_err.
